// File: rtl/jtcop_romslot.sv
// -----------------------------------------------------------------------------
// jtcop_romslot
//
// One-entry read cache between a 32-bit ROM client (BAC06 tile fetcher or
// object ROM fetcher) and a 16-bit SDRAM back-end. A client miss starts a
// two-beat SDRAM burst. The two 16-bit beats are assembled into one 32-bit
// word, and that word stays cached until a different address is requested or
// flush is asserted.
//
// Parameters
//   AW      client word-address width. The back-end address is AW+1 bits wide.
//   LATCH0  1: data holds its value while ok is low.
//           0: data tracks the cached word register at all times.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       invalidates the cached word (ROM download or bank change)
//   cs          client read request
//   addr        client 32-bit word address
//   data        returned 32-bit word
//   ok          data is valid for the current addr
//   sdram_req   back-end request, held high until sdram_ack
//   sdram_addr  back-end 16-bit word address, {addr, 1'b0}
//   sdram_ack   one-cycle pulse, request accepted
//   sdram_dst   one-cycle pulse per 16-bit beat on sdram_din
//   sdram_din   beat data, low half first
// -----------------------------------------------------------------------------
module jtcop_romslot #(
  parameter int AW     = 18,
  parameter bit LATCH0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data,
  output logic          ok,
  output logic          sdram_req,
  output logic [AW:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_din
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    BEAT0,
    BEAT1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] tag;
  logic          valid;
  logic [31:0]   word;
  logic [15:0]   lo_buf;

  logic          hit;
  logic          ok_next;
  logic          start_fetch;
  logic          take_ack;
  logic          load_lo;
  logic          load_hi;

  // A hit is judged against the tag that is valid now. A fetch still in
  // flight does not count until its second beat has been stored.
  assign hit     = cs & valid & (addr == tag);
  // flush drops ok on the same edge that clears valid.
  assign ok_next = hit & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case.
  // A path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    take_ack    = 1'b0;
    load_lo     = 1'b0;
    load_hi     = 1'b0;
    case (state)
      IDLE: begin
        if (cs && !hit && !flush) begin
          start_fetch = 1'b1;
          state_next  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          take_ack   = 1'b1;
          state_next = BEAT0;
        end
      end
      BEAT0: begin
        if (sdram_dst) begin
          load_lo    = 1'b1;
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        if (sdram_dst) begin
          load_hi    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and back-end request
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments. Every register
  // then samples the values from before the edge, whatever order the
  // statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state <= state_next;
      if (start_fetch) begin
        sdram_req  <= 1'b1;
        sdram_addr <= {addr, 1'b0};
      end else if (take_ack) begin
        sdram_req  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cache entry
  // ---------------------------------------------------------------------------
  // The first beat is held in lo_buf. The whole word is written together with
  // the tag on the second beat, so word always belongs to tag. That matters
  // when the client switches back to the cached address while a fetch for
  // some other address is still in progress.
  // NOTE: the cache entry is a plain register, not a RAM. It is cleared on
  // reset so that data reads as zero and the first request after reset
  // always misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_buf <= '0;
      word   <= '0;
      tag    <= '0;
      valid  <= 1'b0;
    end else begin
      if (load_lo) begin
        lo_buf <= sdram_din;
      end
      if (load_hi) begin
        word <= {sdram_din, lo_buf};
        tag  <= sdram_addr[AW:1];
      end
      // flush wins over a fill on the same edge. The word and tag are still
      // written, but the entry stays invalid.
      if (flush) begin
        valid <= 1'b0;
      end else if (load_hi) begin
        valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Client outputs
  // ---------------------------------------------------------------------------
  // With LATCH0 set, data is reloaded only on cycles where ok will be high.
  // It is therefore frozen while ok is low. Because word always matches tag,
  // a reload while ok stays high leaves data unchanged unless the tag itself
  // moved to the address now requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok   <= 1'b0;
      data <= '0;
    end else begin
      ok <= ok_next;
      if (ok_next || !LATCH0) begin
        data <= word;
      end
    end
  end

endmodule

// File: tb/tb_jtcop_romslot.sv
// -----------------------------------------------------------------------------
// tb_jtcop_romslot
//
// Directed bench for jtcop_romslot with default parameters (AW=18, LATCH0=0).
// Each task drives one scenario and compares the outputs against
// hand-computed values one nanosecond after the rising edge that produces them.
// -----------------------------------------------------------------------------
module tb_jtcop_romslot;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        cs;
  logic [17:0] addr;
  logic [31:0] data;
  logic        ok;
  logic        sdram_req;
  logic [18:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [15:0] sdram_din;

  int n_checks;
  int n_fail;

  jtcop_romslot dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cs         (cs),
    .addr       (addr),
    .data       (data),
    .ok         (ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_din  (sdram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    sdram_dst = 1'b1;
    sdram_din = d;
    step();
    sdram_dst = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    // Checked before any clock edge, so the reset must act asynchronously.
    n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", sdram_req); end
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", ok); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", data); end
    n_checks++; if (sdram_addr !== 19'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000", sdram_addr); end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (sdram_req !== 1'b0 || ok !== 1'b0) begin n_fail++; $display("FAIL reset_release: req=%b ok=%b want 0 0", sdram_req, ok); end
  endtask

  task automatic test_cold_miss();
    cs   = 1'b1;
    addr = 18'h00123;
    step();
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL cold_req1: got %b want 1", sdram_req); end
    n_checks++; if (sdram_addr !== 19'h00246) begin n_fail++; $display("FAIL cold_addr: got %h want 00246", sdram_addr); end
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL cold_ok1: got %b want 0", ok); end
    step();
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL cold_req2: got %b want 1", sdram_req); end
    pulse_ack();
    n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_after_ack: got %b want 0", sdram_req); end
    step();
    beat(16'hBEEF);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL cold_ok_beat0: got %b want 0", ok); end
    beat(16'hDEAD);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL cold_ok_beat1: got %b want 0", ok); end
    step();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cold_ok: got %b want 1", ok); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold_data: got %h want deadbeef", data); end
    n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_done: got %b want 0", sdram_req); end
  endtask

  task automatic test_hit();
    cs = 1'b0;
    step();
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL hit_cs_low_ok: got %b want 0", ok); end
    step();
    cs   = 1'b1;
    addr = 18'h00123;
    step();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hit_ok: got %b want 1", ok); end
    n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL hit_req: got %b want 0", sdram_req); end
    n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data: got %h want deadbeef", data); end
    step();
    n_checks++; if (sdram_req !== 1'b0 || ok !== 1'b1) begin n_fail++; $display("FAIL hit_hold: req=%b ok=%b want 0 1", sdram_req, ok); end
  endtask

  task automatic test_addr_change();
    addr = 18'h00010;
    step();
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL chg_req: got %b want 1", sdram_req); end
    n_checks++; if (sdram_addr !== 19'h00020) begin n_fail++; $display("FAIL chg_addr0: got %h want 00020", sdram_addr); end
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL chg_ok_drop: got %b want 0", ok); end
    pulse_ack();
    addr = 18'h00011;
    beat(16'h1111);
    beat(16'h2222);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL chg_ok_old: got %b want 0", ok); end
    // Back-to-back: the new miss is issued on the edge right after the fill.
    step();
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req: got %b want 1", sdram_req); end
    n_checks++; if (sdram_addr !== 19'h00022) begin n_fail++; $display("FAIL b2b_addr: got %h want 00022", sdram_addr); end
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL b2b_ok: got %b want 0", ok); end
    pulse_ack();
    beat(16'h3333);
    beat(16'h4444);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL chg_ok_early: got %b want 0", ok); end
    step();
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL chg_ok_new: got %b want 1", ok); end
    n_checks++; if (data !== 32'h44443333) begin n_fail++; $display("FAIL chg_data: got %h want 44443333", data); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL flush_ok: got %b want 0", ok); end
    step();
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL flush_rereq: got %b want 1", sdram_req); end
    n_checks++; if (sdram_addr !== 19'h00022) begin n_fail++; $display("FAIL flush_rereq_addr: got %h want 00022", sdram_addr); end
    pulse_ack();
    beat(16'h1234);
    beat(16'h5678);
    step();
    n_checks++; if (ok !== 1'b1 || data !== 32'h56781234) begin n_fail++; $display("FAIL flush_refill: ok=%b data=%h want 1 56781234", ok, data); end
    // A flush that coincides with the second beat must leave the entry invalid.
    addr = 18'h00050;
    step();
    n_checks++; if (sdram_req !== 1'b1 || sdram_addr !== 19'h000A0) begin n_fail++; $display("FAIL race_req: req=%b addr=%h want 1 000a0", sdram_req, sdram_addr); end
    pulse_ack();
    beat(16'h5555);
    flush = 1'b1;
    beat(16'h6666);
    flush = 1'b0;
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL race_ok0: got %b want 0", ok); end
    step();
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL race_ok1: got %b want 0", ok); end
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL race_rereq: got %b want 1", sdram_req); end
    // A flush while waiting for the ack must not cancel the request.
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_req: got %b want 1", sdram_req); end
    pulse_ack();
    beat(16'h7777);
    beat(16'h8888);
    step();
    n_checks++; if (ok !== 1'b1 || data !== 32'h88887777) begin n_fail++; $display("FAIL race_refill: ok=%b data=%h want 1 88887777", ok, data); end
  endtask

  task automatic test_reset_mid_fetch();
    addr = 18'h00070;
    step();
    n_checks++; if (sdram_req !== 1'b1 || sdram_addr !== 19'h000E0) begin n_fail++; $display("FAIL rmf_req: req=%b addr=%h want 1 000e0", sdram_req, sdram_addr); end
    pulse_ack();
    // Now in BEAT0. Assert reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sdram_req !== 1'b0 || ok !== 1'b0) begin n_fail++; $display("FAIL rmf_async: req=%b ok=%b want 0 0", sdram_req, ok); end
    n_checks++; if (data !== 32'h0 || sdram_addr !== 19'h0) begin n_fail++; $display("FAIL rmf_clear: data=%h addr=%h want 0 0", data, sdram_addr); end
    cs = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    // Late ack and dst after reset release must be ignored.
    sdram_ack = 1'b1;
    beat(16'hAAAA);
    sdram_ack = 1'b0;
    n_checks++; if (sdram_req !== 1'b0 || ok !== 1'b0) begin n_fail++; $display("FAIL rmf_stray: req=%b ok=%b want 0 0", sdram_req, ok); end
    beat(16'hABAB);
    step();
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL rmf_stray_data: got %h want 00000000", data); end
    cs   = 1'b1;
    addr = 18'h00070;
    step();
    n_checks++; if (sdram_req !== 1'b1 || sdram_addr !== 19'h000E0) begin n_fail++; $display("FAIL rmf_rereq: req=%b addr=%h want 1 000e0", sdram_req, sdram_addr); end
    pulse_ack();
    beat(16'hBBBB);
    beat(16'hCCCC);
    step();
    n_checks++; if (ok !== 1'b1 || data !== 32'hCCCCBBBB) begin n_fail++; $display("FAIL rmf_refill: ok=%b data=%h want 1 ccccbbbb", ok, data); end
  endtask

  task automatic test_stray_dst();
    beat(16'hDDDD);
    n_checks++; if (ok !== 1'b1 || data !== 32'hCCCCBBBB) begin n_fail++; $display("FAIL stray0: ok=%b data=%h want 1 ccccbbbb", ok, data); end
    n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL stray_req: got %b want 0", sdram_req); end
    beat(16'hEEEE);
    step();
    n_checks++; if (ok !== 1'b1 || data !== 32'hCCCCBBBB) begin n_fail++; $display("FAIL stray1: ok=%b data=%h want 1 ccccbbbb", ok, data); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    cs        = 1'b0;
    addr      = '0;
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    sdram_din = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_addr_change();
    test_flush();
    test_reset_mid_fetch();
    test_stray_dst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
